// File: rtl/tpu_pkg.sv
// Shared TPU definitions: default array geometry, result-writeback FSM states
// and the column slice helper used to pack/unpack per-column partial sums.
package tpu_pkg;

   localparam int unsigned DEFAULT_MATRIX_SIZE    = 8;
   localparam int unsigned DEFAULT_PARTIAL_SUM_BW = 20;
   localparam int unsigned DEFAULT_ADDRESSSIZE    = 10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } wb_state_e;

   // Lowest bit of column 'col' inside a packed row of 'bw'-wide columns.
   function automatic int unsigned col_lsb(input int unsigned col, input int unsigned bw);
      return col * bw;
   endfunction

endpackage

// File: rtl/deskew_delay_line.sv
// Fixed-depth shift register with synchronous clear; DEPTH=0 degenerates to a wire.
module deskew_delay_line #(
   parameter int unsigned DEPTH = 1,
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             clr,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   if (DEPTH == 0) begin : g_wire
      logic unused_ctrl;
      assign unused_ctrl = &{1'b0, clk, rstn, clr};
      assign dout        = din;
   end else begin : g_shift
      logic [WIDTH-1:0] stage [DEPTH];

      always_ff @(posedge clk or negedge rstn) begin
         if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
         end else if (clr) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
         end else begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
         end
      end

      assign dout = stage[DEPTH-1];
   end

endmodule

// File: rtl/result_writeback.sv
// Deskews the staggered column partial sums leaving the PE array into aligned rows
// and writes them to the result SRAM at consecutive (wrapping) addresses.
module result_writeback
   import tpu_pkg::*;
#(
   parameter int unsigned MATRIX_SIZE    = DEFAULT_MATRIX_SIZE,
   parameter int unsigned PARTIAL_SUM_BW = DEFAULT_PARTIAL_SUM_BW,
   parameter int unsigned ADDRESSSIZE    = DEFAULT_ADDRESSSIZE,
   parameter int unsigned NUM_ROWS       = 8
) (
   input  logic                                  clk,
   input  logic                                  rstn,
   input  logic                                  start,
   input  logic [ADDRESSSIZE-1:0]                base_addr,
   input  logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0] psum_in,
   input  logic [MATRIX_SIZE-1:0]                psum_valid,
   output logic                                  wr_en,
   output logic [ADDRESSSIZE-1:0]                wr_addr,
   output logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0] wr_data,
   output logic                                  busy,
   output logic                                  done,
   output logic                                  err
);

   localparam int unsigned N      = MATRIX_SIZE;
   localparam int unsigned ROW_W  = PARTIAL_SUM_BW * N;
   localparam int unsigned LANE_W = PARTIAL_SUM_BW + 1;
   localparam int unsigned CNT_W  = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

   wb_state_e              state, state_n;
   logic [ADDRESSSIZE-1:0] base_q, base_n;
   logic [CNT_W-1:0]       row_cnt, row_cnt_n;
   logic                   wr_en_n, busy_n, done_n, err_n;
   logic [ADDRESSSIZE-1:0] wr_addr_n;
   logic [ROW_W-1:0]       wr_data_n;

   logic                   line_clr;
   logic [N-1:0]           dly_valid;
   logic [ROW_W-1:0]       dly_data;

   // Delay lines only run in RUN; outside it they are held cleared so stale beats die.
   assign line_clr = (state != ST_RUN);

   // Column c is delayed N-1-c cycles so every column of a row lands together.
   for (genvar c = 0; c < N; c++) begin : g_col
      logic [LANE_W-1:0] lane_out;

      deskew_delay_line #(
         .DEPTH (N - 1 - c),
         .WIDTH (LANE_W)
      ) u_dly (
         .clk  (clk),
         .rstn (rstn),
         .clr  (line_clr),
         .din  ({psum_valid[c], psum_in[col_lsb(c, PARTIAL_SUM_BW) +: PARTIAL_SUM_BW]}),
         .dout (lane_out)
      );

      assign dly_valid[c] = lane_out[LANE_W-1];
      assign dly_data[col_lsb(c, PARTIAL_SUM_BW) +: PARTIAL_SUM_BW] = lane_out[PARTIAL_SUM_BW-1:0];
   end

   // State register and registered outputs.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state   <= ST_IDLE;
         base_q  <= '0;
         row_cnt <= '0;
         wr_en   <= 1'b0;
         wr_addr <= '0;
         wr_data <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         err     <= 1'b0;
      end else begin
         state   <= state_n;
         base_q  <= base_n;
         row_cnt <= row_cnt_n;
         wr_en   <= wr_en_n;
         wr_addr <= wr_addr_n;
         wr_data <= wr_data_n;
         busy    <= busy_n;
         done    <= done_n;
         err     <= err_n;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_n   = state;
      base_n    = base_q;
      row_cnt_n = row_cnt;
      wr_en_n   = 1'b0;
      wr_addr_n = wr_addr;
      wr_data_n = wr_data;
      busy_n    = 1'b0;
      done_n    = 1'b0;
      err_n     = err;

      unique case (state)
         ST_IDLE: begin
            if (start) begin
               base_n    = base_addr;
               row_cnt_n = '0;
               err_n     = 1'b0;
               busy_n    = 1'b1;
               state_n   = ST_RUN;
            end
         end

         ST_RUN: begin
            busy_n = 1'b1;
            if (&dly_valid) begin
               wr_en_n   = 1'b1;
               wr_addr_n = base_q + ADDRESSSIZE'(row_cnt);
               wr_data_n = dly_data;
               row_cnt_n = row_cnt + 1'b1;
               if (row_cnt == CNT_W'(NUM_ROWS - 1)) state_n = ST_DONE;
            end else if (|dly_valid) begin
               // A torn row means the upstream skew broke; drop it and flag.
               err_n = 1'b1;
            end
         end

         ST_DONE: begin
            done_n  = 1'b1;
            state_n = ST_IDLE;
         end

         default: state_n = ST_IDLE;
      endcase
   end

endmodule
